// File: rtl/demux_1to4_64_buf.sv
// -----------------------------------------------------------------------------
// demux_1to4_64_buf
//   Registered 1-to-4 demultiplexer with valid/ready handshakes. A single
//   producer word is steered to one of four consumer lanes by i_select. Each
//   lane owns a one-entry holding buffer, so a stalled consumer only blocks
//   traffic aimed at its own lane. Each lane also counts delivered words.
//
// Ports
//   clk                   rising-edge clock
//   reset                 synchronous, active-high reset
//   i_valid               producer word valid
//   i_select[1:0]         destination lane (0=A, 1=B, 2=C, 3=D)
//   i_data[WIDTH-1:0]     producer word
//   o_ready               producer word is accepted this cycle when i_valid=1
//   o_valid[3:0]          bit k: lane k holds a word
//   i_ready[3:0]          bit k: consumer k takes lane k this cycle
//   o_data_0..3           lane data (only meaningful while o_valid[k]=1)
//   o_count_0..3          words delivered per lane, wraps modulo 2^CNT_W
//   o_busy                any lane holds a word
// -----------------------------------------------------------------------------
module demux_1to4_64_buf #(
  parameter int WIDTH = 64,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_valid,
  input  logic [1:0]       i_select,
  input  logic [WIDTH-1:0] i_data,
  output logic             o_ready,
  output logic [3:0]       o_valid,
  input  logic [3:0]       i_ready,
  output logic [WIDTH-1:0] o_data_0,
  output logic [WIDTH-1:0] o_data_1,
  output logic [WIDTH-1:0] o_data_2,
  output logic [WIDTH-1:0] o_data_3,
  output logic [CNT_W-1:0] o_count_0,
  output logic [CNT_W-1:0] o_count_1,
  output logic [CNT_W-1:0] o_count_2,
  output logic [CNT_W-1:0] o_count_3,
  output logic             o_busy
);

  logic [3:0]       full_q, full_d;
  logic [3:0]       load, drain;
  logic             accept;
  logic [WIDTH-1:0] buf_q [4];
  logic [WIDTH-1:0] buf_d [4];
  logic [CNT_W-1:0] cnt_q [4];
  logic [CNT_W-1:0] cnt_d [4];

  always_comb begin
    // A full lane can still take a new word if its consumer drains the old
    // one on the same edge; this is what gives one word per cycle per lane.
    o_ready = ~full_q[i_select] | i_ready[i_select];
    accept  = i_valid & o_ready;
    load    = accept ? (4'b0001 << i_select) : 4'b0000;
    drain   = full_q & i_ready;
    // Load wins over drain so a same-edge refill keeps the lane full.
    full_d  = (full_q & ~drain) | load;
    for (int k = 0; k < 4; k++) begin
      buf_d[k] = load[k] ? i_data : buf_q[k];
      cnt_d[k] = cnt_q[k] + CNT_W'(drain[k]);
    end
  end

  // Lane state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      full_q <= 4'b0000;
      for (int k = 0; k < 4; k++) begin
        buf_q[k] <= '0;
        cnt_q[k] <= '0;
      end
    end else begin
      full_q <= full_d;
      for (int k = 0; k < 4; k++) begin
        buf_q[k] <= buf_d[k];
        cnt_q[k] <= cnt_d[k];
      end
    end
  end

  assign o_valid   = full_q;
  assign o_busy    = |full_q;
  assign o_data_0  = buf_q[0];
  assign o_data_1  = buf_q[1];
  assign o_data_2  = buf_q[2];
  assign o_data_3  = buf_q[3];
  assign o_count_0 = cnt_q[0];
  assign o_count_1 = cnt_q[1];
  assign o_count_2 = cnt_q[2];
  assign o_count_3 = cnt_q[3];

endmodule

// File: tb/tb_demux_1to4_64_buf.sv
module tb_demux_1to4_64_buf;

  logic        clk = 1'b0;
  logic        reset;
  logic        iv;
  logic [1:0]  isel;
  logic [63:0] idata;
  logic [3:0]  irdy;
  logic        ordy;
  logic [3:0]  ov;
  logic [63:0] od0, od1, od2, od3;
  logic [15:0] oc0, oc1, oc2, oc3;
  logic        obusy;

  int errs   = 0;
  int checks = 0;

  always #5 clk = ~clk;

  demux_1to4_64_buf dut (
    .clk       (clk),
    .reset     (reset),
    .i_valid   (iv),
    .i_select  (isel),
    .i_data    (idata),
    .o_ready   (ordy),
    .o_valid   (ov),
    .i_ready   (irdy),
    .o_data_0  (od0),
    .o_data_1  (od1),
    .o_data_2  (od2),
    .o_data_3  (od3),
    .o_count_0 (oc0),
    .o_count_1 (oc1),
    .o_count_2 (oc2),
    .o_count_3 (oc3),
    .o_busy    (obusy)
  );

  task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference model: each lane is a queue of capacity one; a word enters when
  // the queue is empty or its consumer removes the current word this edge.
  logic [63:0] mq [4][$];
  logic [63:0] m_last [4];
  logic [15:0] m_cnt [4];
  bit          model_ok = 0;

  always @(posedge clk) begin
    bit acc;
    if (reset) begin
      for (int k = 0; k < 4; k++) begin
        mq[k].delete();
        m_last[k] = 64'd0;
        m_cnt[k]  = 16'd0;
      end
      model_ok = 1;
    end else begin
      acc = iv && (mq[isel].size() == 0 || irdy[isel]);
      for (int k = 0; k < 4; k++) begin
        if (mq[k].size() != 0 && irdy[k]) begin
          void'(mq[k].pop_front());
          m_cnt[k] = m_cnt[k] + 16'd1;
        end
      end
      if (acc) begin
        mq[isel].push_back(idata);
        m_last[isel] = idata;
      end
    end
  end

  always @(negedge clk) begin
    logic [3:0] ev;
    if (model_ok) begin
      for (int k = 0; k < 4; k++) ev[k] = (mq[k].size() != 0);
      check("o_valid", {60'd0, ov}, {60'd0, ev});
      check("o_busy", {63'd0, obusy}, {63'd0, (ev != 4'b0000)});
      check("o_ready", {63'd0, ordy}, {63'd0, (mq[isel].size() == 0 || irdy[isel])});
      check("o_data_0", od0, m_last[0]);
      check("o_data_1", od1, m_last[1]);
      check("o_data_2", od2, m_last[2]);
      check("o_data_3", od3, m_last[3]);
      check("o_count_0", {48'd0, oc0}, {48'd0, m_cnt[0]});
      check("o_count_1", {48'd0, oc1}, {48'd0, m_cnt[1]});
      check("o_count_2", {48'd0, oc2}, {48'd0, m_cnt[2]});
      check("o_count_3", {48'd0, oc3}, {48'd0, m_cnt[3]});
    end
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1; iv = 1'b0; isel = 2'd0; idata = 64'd0; irdy = 4'b0000;
    cyc(); cyc();
    reset = 1'b0;
    #1;
    check("rst_valid", {60'd0, ov}, 64'd0);
    check("rst_ready", {63'd0, ordy}, 64'd1);
    check("rst_busy", {63'd0, obusy}, 64'd0);
    check("rst_count0", {48'd0, oc0}, 64'd0);

    // first word to lane 2
    iv = 1'b1; isel = 2'd2; idata = 64'hDEADBEEF_00000001; irdy = 4'b0000;
    cyc();
    iv = 1'b0;
    check("t1_valid", {60'd0, ov}, 64'h4);
    check("t1_data2", od2, 64'hDEADBEEF_00000001);
    check("t1_data0", od0, 64'd0);
    check("t1_busy", {63'd0, obusy}, 64'd1);

    // stalled lane 2 refuses, lane 0 still accepts
    iv = 1'b1; isel = 2'd2; idata = 64'h5555;
    #1;
    check("t2_stall_ready", {63'd0, ordy}, 64'd0);
    cyc();
    check("t2_data2_held", od2, 64'hDEADBEEF_00000001);
    isel = 2'd0; idata = 64'hA0;
    #1;
    check("t2_lane0_ready", {63'd0, ordy}, 64'd1);
    cyc();
    iv = 1'b0;
    check("t2_valid", {60'd0, ov}, 64'h5);
    check("t2_data0", od0, 64'hA0);

    // back-to-back stream into lane 1
    reset = 1'b1; cyc(); reset = 1'b0;
    irdy = 4'b0010; iv = 1'b1; isel = 2'd1;
    for (int i = 1; i <= 3; i++) begin
      idata = 64'(i);
      cyc();
      check("t3_stream_data1", od1, 64'(i));
      check("t3_stream_valid1", {63'd0, ov[1]}, 64'd1);
    end
    iv = 1'b0;
    cyc();
    irdy = 4'b0000;
    check("t3_count1", {48'd0, oc1}, 64'd3);

    // load lane 0 while draining lane 3
    reset = 1'b1; cyc(); reset = 1'b0;
    iv = 1'b1; isel = 2'd3; idata = 64'h33;
    cyc();
    check("t4_pre_valid", {60'd0, ov}, 64'h8);
    isel = 2'd0; idata = 64'h44; irdy = 4'b1000;
    cyc();
    iv = 1'b0; irdy = 4'b0000;
    check("t4_valid", {60'd0, ov}, 64'h1);
    check("t4_count3", {48'd0, oc3}, 64'd1);

    // counter wrap on lane 0
    reset = 1'b1; cyc(); reset = 1'b0;
    iv = 1'b1; isel = 2'd0; irdy = 4'b0001;
    for (int i = 0; i < 65536; i++) begin
      idata = 64'(i);
      cyc();
    end
    check("t5_count_ffff", {48'd0, oc0}, 64'hFFFF);
    iv = 1'b0;
    cyc();
    irdy = 4'b0000;
    check("t5_count_wrap", {48'd0, oc0}, 64'd0);

    // all lanes full, reset dominates accept and drains
    iv = 1'b1;
    for (int s = 0; s < 4; s++) begin
      isel = 2'(s); idata = 64'h100 + 64'(s);
      cyc();
    end
    check("t6_all_full", {60'd0, ov}, 64'hF);
    reset = 1'b1; isel = 2'd1; idata = 64'hFFFF; irdy = 4'b1111;
    cyc();
    reset = 1'b0; iv = 1'b0; irdy = 4'b0000;
    #1;
    check("t6_valid", {60'd0, ov}, 64'd0);
    check("t6_ready", {63'd0, ordy}, 64'd1);
    check("t6_data3", od3, 64'd0);
    check("t6_count0", {48'd0, oc0}, 64'd0);
    cyc();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
